// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//
// Program-counter generator for the first fetch stage. Produces one
// fetch-block address per advance, accepts branch/jump redirects, holds a
// redirect that arrives while fetch is stalled, and reports which slots of
// the current block are live after a mid-block redirect.
//
// Parameters
//   FETCH_WIDTH   instructions per fetch block (1, 2 or 4); BLK = 4*FETCH_WIDTH
//   RESET_VECTOR  boot address, BLK-aligned
//   RESET_LEAD    blocks the PC starts ahead of RESET_VECTOR
//
// Ports
//   clock_i           rising-edge clock
//   reset_n_i         synchronous active-low reset
//   pc_we_i           advance enable (downstream ready)
//   redirect_valid_i  redirect request this cycle
//   redirect_pc_i     redirect target, bits [1:0] ignored
//   pc_o              current fetch address
//   pc_valid_o        pc_o is a real fetch address (low only in RESET)
//   slot_mask_o       bit i set: slot i of the block at pc_o is live
//   flush_o           one-cycle pulse: in-flight downstream block is wrong-path
//   stall_o           a redirect is latched and not yet applied
// ---------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter int          FETCH_WIDTH  = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          RESET_LEAD   = 1
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   pc_we_i,
    input  logic                   redirect_valid_i,
    input  logic [31:0]            redirect_pc_i,
    output logic [31:0]            pc_o,
    output logic                   pc_valid_o,
    output logic [FETCH_WIDTH-1:0] slot_mask_o,
    output logic                   flush_o,
    output logic                   stall_o
);

    localparam logic [31:0]            BLK_BYTES = 32'(4 * FETCH_WIDTH);
    localparam logic [31:0]            PC_BOOT   = RESET_VECTOR + 32'(RESET_LEAD) * BLK_BYTES;
    localparam logic [FETCH_WIDTH-1:0] MASK_ALL  = {FETCH_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_PEND
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [31:0]            r_pc;
    logic [31:0]            w_pc_next;
    logic [31:0]            r_pend_pc;
    logic [31:0]            w_pend_pc_next;
    logic [FETCH_WIDTH-1:0] r_mask;
    logic [FETCH_WIDTH-1:0] w_mask_next;
    logic                   r_flush;
    logic                   w_flush_next;

    // Word-aligned target; the offset within the block is kept so the slot
    // mask can suppress the instructions before the branch target.
    logic [31:0] w_redirect_pc;
    logic [31:0] w_seq_pc;

    assign w_redirect_pc = redirect_pc_i & ~32'h3;
    assign w_seq_pc      = (r_pc & ~(BLK_BYTES - 32'd1)) + BLK_BYTES;

    // Slot i is live iff i is at or after the word offset of pc within its
    // block. With FETCH_WIDTH = 1 the offset is always 0, so the mask is 1.
    function automatic logic [FETCH_WIDTH-1:0] slot_mask(input logic [31:0] pc);
        logic [31:0]            slot;
        logic [FETCH_WIDTH-1:0] mask;
        slot = (pc >> 2) & 32'(FETCH_WIDTH - 1);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask[i] = (32'(i) >= slot);
        end
        return mask;
    endfunction

    // NOTE: every signal gets its hold/default value first so no path through
    // the case leaves one unassigned and infers a latch.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_mask_next    = r_mask;
        w_pend_pc_next = r_pend_pc;
        w_flush_next   = 1'b0;

        case (r_state)
            // First edge out of reset only validates the boot PC.
            ST_RESET: w_state_next = ST_RUN;

            ST_RUN, ST_PEND: begin
                if (pc_we_i) begin
                    w_state_next = ST_RUN;
                    if (redirect_valid_i) begin
                        // Incoming target beats (and discards) any pending one.
                        w_pc_next    = w_redirect_pc;
                        w_mask_next  = slot_mask(w_redirect_pc);
                        w_flush_next = 1'b1;
                    end else if (r_state == ST_PEND) begin
                        w_pc_next    = r_pend_pc;
                        w_mask_next  = slot_mask(r_pend_pc);
                        w_flush_next = 1'b1;
                    end else begin
                        w_pc_next    = w_seq_pc;
                        w_mask_next  = MASK_ALL;
                    end
                end else if (redirect_valid_i) begin
                    // Stalled: latch the target, newest request wins.
                    w_pend_pc_next = w_redirect_pc;
                    w_state_next   = ST_PEND;
                end
            end

            default: w_state_next = ST_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_RESET;
            r_pc      <= PC_BOOT;
            r_mask    <= MASK_ALL;
            r_flush   <= 1'b0;
            // NOTE: the pending target is cleared on reset even though it is
            // only read in PEND, so no stale address survives into a new run.
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_mask    <= w_mask_next;
            r_flush   <= w_flush_next;
            r_pend_pc <= w_pend_pc_next;
        end
    end

    assign pc_o        = r_pc;
    assign slot_mask_o = r_mask;
    assign flush_o     = r_flush;
    assign pc_valid_o  = (r_state != ST_RESET);
    assign stall_o     = (r_state == ST_PEND);

endmodule
